// File: rtl/muldiv_ctrl_pkg.sv
// Shared definitions for the mul/div controller: opcodes, FSM states and
// the HI/LO write-source select.
package muldiv_ctrl_pkg;

  localparam int unsigned DATA_W = 32;

  typedef enum logic [2:0] {
    NOP   = 3'd0,
    MULT  = 3'd1,
    MULTU = 3'd2,
    DIV   = 3'd3,
    DIVU  = 3'd4,
    MTHI  = 3'd5,
    MTLO  = 3'd6
  } op_e;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    MUL_WAIT = 3'd1,
    DIV_WAIT = 3'd2,
    DONE     = 3'd3,
    ABORT    = 3'd4
  } state_e;

  typedef enum logic {
    SRC_GPR = 1'b0,
    SRC_RES = 1'b1
  } hilo_src_e;

  function automatic logic is_mul_op(input logic [2:0] op);
    return (op == MULT) || (op == MULTU);
  endfunction

  function automatic logic is_div_op(input logic [2:0] op);
    return (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/muldiv_ctrl_if.sv
// Handshake bundle between the controller and the external multiplier and
// divider units. The controller is the master; the units are slaves.
interface muldiv_ctrl_if;
  import muldiv_ctrl_pkg::*;

  logic              mul_opn_valid;
  logic [DATA_W-1:0] mul_a;
  logic [DATA_W-1:0] mul_b;
  logic              mul_sign;
  logic              mul_res_ready;
  logic              mul_res_valid;
  logic [63:0]       mul_result;

  logic              div_opn_valid;
  logic [DATA_W-1:0] div_a;
  logic [DATA_W-1:0] div_b;
  logic              div_sign;
  logic              div_res_ready;
  logic              div_res_valid;
  logic [63:0]       div_result;   // {remainder, quotient}

  modport master (
    output mul_opn_valid, mul_a, mul_b, mul_sign, mul_res_ready,
    input  mul_res_valid, mul_result,
    output div_opn_valid, div_a, div_b, div_sign, div_res_ready,
    input  div_res_valid, div_result
  );

  modport slave (
    input  mul_opn_valid, mul_a, mul_b, mul_sign, mul_res_ready,
    output mul_res_valid, mul_result,
    input  div_opn_valid, div_a, div_b, div_sign, div_res_ready,
    output div_res_valid, div_result
  );

endinterface

// File: rtl/muldiv_ctrl_hilo_reg.sv
// Architectural HI/LO register pair. Each half has its own write enable;
// the source is either a GPR value (MTHI/MTLO) or a 64-bit unit result.
module muldiv_ctrl_hilo_reg
  import muldiv_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_we_hi,
  input  logic              i_we_lo,
  input  hilo_src_e         i_src,
  input  logic [DATA_W-1:0] i_gpr,
  input  logic [63:0]       i_result,
  output logic [DATA_W-1:0] o_hi,
  output logic [DATA_W-1:0] o_lo
);

  logic [DATA_W-1:0] r_hi;
  logic [DATA_W-1:0] r_lo;
  logic [DATA_W-1:0] w_hi_src;
  logic [DATA_W-1:0] w_lo_src;

  // Select the write data for each half from the GPR or the unit result.
  always_comb begin
    w_hi_src = i_gpr;
    w_lo_src = i_gpr;
    if (i_src == SRC_RES) begin
      w_hi_src = i_result[63:32];
      w_lo_src = i_result[31:0];
    end
  end

  // HI/LO storage, cleared by reset, updated only on an enabled write.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_hi <= '0;
      r_lo <= '0;
    end else begin
      if (i_we_hi) r_hi <= w_hi_src;
      if (i_we_lo) r_lo <= w_lo_src;
    end
  end

  assign o_hi = r_hi;
  assign o_lo = r_lo;

endmodule

// File: rtl/muldiv_ctrl.sv
// EX-stage multiply/divide controller: issues operations to the external
// units, stalls EX until the result is committed to HI/LO, handles flush
// (aborting and draining any in-flight result) and MTHI/MTLO writes.
module muldiv_ctrl
  import muldiv_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [2:0]        ex_op,
  input  logic [DATA_W-1:0] rs_val,
  input  logic [DATA_W-1:0] rt_val,
  input  logic              pipe_stall,
  input  logic              flush,
  output logic              stall_out,
  muldiv_ctrl_if.master     bus,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  state_e            r_state;
  state_e            w_state_nxt;

  logic              r_mul_opn_valid;
  logic [DATA_W-1:0] r_mul_a;
  logic [DATA_W-1:0] r_mul_b;
  logic              r_mul_sign;
  logic              r_div_opn_valid;
  logic [DATA_W-1:0] r_div_a;
  logic [DATA_W-1:0] r_div_b;
  logic              r_div_sign;

  logic              w_op_mul;
  logic              w_div_ok;
  logic              w_accept;
  logic              w_issue_mul;
  logic              w_issue_div;
  logic              w_we_hi;
  logic              w_we_lo;
  hilo_src_e         w_src;
  logic [63:0]       w_result;

  // A divide by zero is treated as a no-op: it never starts the divider.
  assign w_op_mul    = is_mul_op(ex_op);
  assign w_div_ok    = is_div_op(ex_op) && (rt_val != '0);
  assign w_accept    = ex_valid && !flush && (r_state == IDLE);
  assign w_issue_mul = w_accept && w_op_mul;
  assign w_issue_div = w_accept && w_div_ok;

  // State register.
  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  // Next-state logic; flush wins over issue and over result commit.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (w_issue_mul)      w_state_nxt = MUL_WAIT;
        else if (w_issue_div) w_state_nxt = DIV_WAIT;
      end
      MUL_WAIT: begin
        if (flush)                   w_state_nxt = bus.mul_res_valid ? IDLE : ABORT;
        else if (bus.mul_res_valid)  w_state_nxt = DONE;
      end
      DIV_WAIT: begin
        if (flush)                   w_state_nxt = bus.div_res_valid ? IDLE : ABORT;
        else if (bus.div_res_valid)  w_state_nxt = DONE;
      end
      DONE: begin
        if (flush || !pipe_stall) w_state_nxt = IDLE;
      end
      ABORT: begin
        // Only one unit can be in flight, so either result ends the drain.
        if (bus.mul_res_valid || bus.div_res_valid) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Outputs: EX stall, result-ready strobes and HI/LO write controls.
  always_comb begin
    stall_out         = ex_valid && (w_op_mul || w_div_ok) && (r_state != DONE);
    bus.mul_res_ready = 1'b0;
    bus.div_res_ready = 1'b0;
    w_we_hi           = 1'b0;
    w_we_lo           = 1'b0;
    w_src             = SRC_GPR;
    w_result          = bus.mul_result;
    case (r_state)
      IDLE: begin
        if (ex_valid && !flush && (ex_op == MTHI)) w_we_hi = 1'b1;
        if (ex_valid && !flush && (ex_op == MTLO)) w_we_lo = 1'b1;
      end
      MUL_WAIT: begin
        bus.mul_res_ready = 1'b1;
        if (bus.mul_res_valid && !flush) begin
          w_we_hi = 1'b1;
          w_we_lo = 1'b1;
          w_src   = SRC_RES;
        end
      end
      DIV_WAIT: begin
        bus.div_res_ready = 1'b1;
        w_result          = bus.div_result;
        if (bus.div_res_valid && !flush) begin
          w_we_hi = 1'b1;
          w_we_lo = 1'b1;
          w_src   = SRC_RES;
        end
      end
      ABORT: begin
        bus.mul_res_ready = 1'b1;
        bus.div_res_ready = 1'b1;
      end
      default: ;
    endcase
  end

  // Operand registers and one-cycle issue pulses toward the units.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_mul_opn_valid <= 1'b0;
      r_mul_a         <= '0;
      r_mul_b         <= '0;
      r_mul_sign      <= 1'b0;
      r_div_opn_valid <= 1'b0;
      r_div_a         <= '0;
      r_div_b         <= '0;
      r_div_sign      <= 1'b0;
    end else begin
      r_mul_opn_valid <= w_issue_mul;
      r_div_opn_valid <= w_issue_div;
      if (w_issue_mul) begin
        r_mul_a    <= rs_val;
        r_mul_b    <= rt_val;
        r_mul_sign <= (ex_op == MULT);
      end
      if (w_issue_div) begin
        r_div_a    <= rs_val;
        r_div_b    <= rt_val;
        r_div_sign <= (ex_op == DIV);
      end
    end
  end

  assign bus.mul_opn_valid = r_mul_opn_valid;
  assign bus.mul_a         = r_mul_a;
  assign bus.mul_b         = r_mul_b;
  assign bus.mul_sign      = r_mul_sign;
  assign bus.div_opn_valid = r_div_opn_valid;
  assign bus.div_a         = r_div_a;
  assign bus.div_b         = r_div_b;
  assign bus.div_sign      = r_div_sign;

  muldiv_ctrl_hilo_reg u_hilo_reg (
    .clk      (clk),
    .rst      (rst),
    .i_we_hi  (w_we_hi),
    .i_we_lo  (w_we_lo),
    .i_src    (w_src),
    .i_gpr    (rs_val),
    .i_result (w_result),
    .o_hi     (hi),
    .o_lo     (lo)
  );

endmodule

// File: tb/tb_muldiv_ctrl.sv
// Testbench for muldiv_ctrl: behavioural multiplier/divider on the slave
// side, a table of single-instruction vectors, and hand-written sequences
// for flush/abort, DONE hold, flush priority and mid-operation reset.
module tb_muldiv_ctrl;
  import muldiv_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        ex_valid;
  logic [2:0]  ex_op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        pipe_stall;
  logic        flush;
  logic        stall_out;
  logic [31:0] hi;
  logic [31:0] lo;

  muldiv_ctrl_if bus ();

  muldiv_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .ex_valid   (ex_valid),
    .ex_op      (ex_op),
    .rs_val     (rs_val),
    .rt_val     (rt_val),
    .pipe_stall (pipe_stall),
    .flush      (flush),
    .stall_out  (stall_out),
    .bus        (bus),
    .hi         (hi),
    .lo         (lo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;
  int mul_issues = 0;
  int div_issues = 0;
  int m_cnt = 0;
  int d_cnt = 0;
  int mul_lat = 2;
  int div_lat = 3;
  logic [63:0] m_res, d_res;
  logic [31:0] cap_a, cap_b;
  logic        cap_sign;
  logic [31:0] eh, el;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] rs;
    logic [31:0] rt;
    int          n_mul;
    int          n_div;
    logic        stall;
    logic        sign;
    logic [31:0] hi;
    logic [31:0] lo;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [63:0] mul_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [63:0] sa, sb;
    if (s) begin
      sa = {{32{a[31]}}, a};
      sb = {{32{b[31]}}, b};
      return sa * sb;
    end
    return {32'd0, a} * {32'd0, b};
  endfunction

  function automatic logic [63:0] div_ref(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [31:0] q, r;
    if (b == 32'd0) return 64'd0;
    if (s) begin
      q = $signed(a) / $signed(b);
      r = $signed(a) % $signed(b);
      return {r, q};
    end
    return {a % b, a / b};
  endfunction

  // Behavioural units: fixed latency after the issue pulse, one-cycle result pulse.
  task automatic unit_model();
    if (rst) begin
      m_cnt = 0;
      d_cnt = 0;
      bus.mul_res_valid = 1'b0;
      bus.div_res_valid = 1'b0;
    end else begin
      bus.mul_res_valid = 1'b0;
      bus.div_res_valid = 1'b0;
      if (m_cnt == 1) begin
        bus.mul_res_valid = 1'b1;
        bus.mul_result    = m_res;
      end
      if (m_cnt > 0) m_cnt--;
      if (d_cnt == 1) begin
        bus.div_res_valid = 1'b1;
        bus.div_result    = d_res;
      end
      if (d_cnt > 0) d_cnt--;
      if (bus.mul_opn_valid) begin
        mul_issues++;
        m_cnt    = mul_lat;
        cap_a    = bus.mul_a;
        cap_b    = bus.mul_b;
        cap_sign = bus.mul_sign;
        m_res    = mul_ref(bus.mul_a, bus.mul_b, bus.mul_sign);
      end
      if (bus.div_opn_valid) begin
        div_issues++;
        d_cnt    = div_lat;
        cap_a    = bus.div_a;
        cap_b    = bus.div_b;
        cap_sign = bus.div_sign;
        d_res    = div_ref(bus.div_a, bus.div_b, bus.div_sign);
      end
    end
  endtask

  task automatic cyc();
    @(negedge clk);
    unit_model();
  endtask

  task automatic drv(input logic v, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    ex_valid = v;
    ex_op    = op;
    rs_val   = a;
    rt_val   = b;
  endtask

  // Hold the current EX instruction until stall drops, then step past its commit edge.
  task automatic finish_op(input string tag);
    int n;
    n = 0;
    while (stall_out && n < 40) begin
      cyc();
      #1;
      n++;
    end
    chk({tag, " completes"}, 64'(n < 40), 64'd1);
    cyc();
    ex_valid = 1'b0;
    ex_op    = NOP;
    #1;
  endtask

  task automatic run_vec(input vec_t v, input string tag);
    int m0, d0;
    m0 = mul_issues;
    d0 = div_issues;
    drv(1'b1, v.op, v.rs, v.rt);
    #1;
    chk({tag, " stall_issue"}, 64'(stall_out), 64'(v.stall));
    finish_op(tag);
    chk({tag, " mul_pulses"}, 64'(mul_issues - m0), 64'(v.n_mul));
    chk({tag, " div_pulses"}, 64'(div_issues - d0), 64'(v.n_div));
    chk({tag, " hi"}, 64'(hi), 64'(v.hi));
    chk({tag, " lo"}, 64'(lo), 64'(v.lo));
    if (v.n_mul + v.n_div > 0) begin
      chk({tag, " sign"}, 64'(cap_sign), 64'(v.sign));
      chk({tag, " operands"}, {cap_a, cap_b}, {v.rs, v.rt});
    end
    eh = v.hi;
    el = v.lo;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, m0, d0;
    rst = 1'b1;
    drv(1'b0, NOP, 32'd0, 32'd0);
    pipe_stall = 1'b0;
    flush      = 1'b0;
    bus.mul_res_valid = 1'b0;
    bus.div_res_valid = 1'b0;
    bus.mul_result    = 64'd0;
    bus.div_result    = 64'd0;

    vecs[0] = '{MULT,  32'hFFFFFFFE, 32'd3,        1, 0, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFA};
    vecs[1] = '{MULTU, 32'hFFFFFFFF, 32'd2,        1, 0, 1'b1, 1'b0, 32'h00000001, 32'hFFFFFFFE};
    vecs[2] = '{DIV,   32'd7,        32'd0,        0, 0, 1'b0, 1'b0, 32'h00000001, 32'hFFFFFFFE};
    vecs[3] = '{DIVU,  32'd100,      32'd7,        0, 1, 1'b1, 1'b0, 32'h00000002, 32'h0000000E};
    vecs[4] = '{DIV,   32'hFFFFFFF9, 32'd2,        0, 1, 1'b1, 1'b1, 32'hFFFFFFFF, 32'hFFFFFFFD};
    vecs[5] = '{MTHI,  32'h12345678, 32'd0,        0, 0, 1'b0, 1'b0, 32'h12345678, 32'hFFFFFFFD};
    vecs[6] = '{MTLO,  32'h9ABCDEF0, 32'd0,        0, 0, 1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0};
    vecs[7] = '{DIVU,  32'd5,        32'd0,        0, 0, 1'b0, 1'b0, 32'h12345678, 32'h9ABCDEF0};
    vecs[8] = '{MULT,  32'h7FFFFFFF, 32'h80000000, 1, 0, 1'b1, 1'b1, 32'hC0000000, 32'h80000000};
    vecs[9] = '{NOP,   32'd1,        32'd1,        0, 0, 1'b0, 1'b0, 32'hC0000000, 32'h80000000};

    // Reset state
    cyc();
    cyc();
    cyc();
    rst = 1'b0;
    #1;
    chk("rst hi", 64'(hi), 64'd0);
    chk("rst lo", 64'(lo), 64'd0);
    chk("rst stall", 64'(stall_out), 64'd0);
    chk("rst opn_valid", {bus.mul_opn_valid, bus.div_opn_valid}, 64'd0);
    chk("rst res_ready", {bus.mul_res_ready, bus.div_res_ready}, 64'd0);
    chk("rst operands", {bus.mul_a, bus.div_b}, 64'd0);
    eh = 32'd0;
    el = 32'd0;

    // Table of single instructions, issued back-to-back
    for (int i = 0; i < 10; i++) run_vec(vecs[i], $sformatf("vec%0d", i));

    // Flush on second MUL_WAIT cycle -> ABORT, drain, then a fresh MULT
    mul_lat = 4;
    m0 = mul_issues;
    cyc();
    drv(1'b1, MULT, 32'd5, 32'd6);
    #1;
    chk("abort stall_issue", 64'(stall_out), 64'd1);
    cyc();
    #1;
    chk("abort opn_pulse", 64'(bus.mul_opn_valid), 64'd1);
    cyc();
    flush = 1'b1;
    #1;
    chk("abort stall_wait", 64'(stall_out), 64'd1);
    cyc();
    flush = 1'b0;
    drv(1'b1, MULT, 32'hFFFFFFFE, 32'd3);
    #1;
    chk("abort ready", {bus.mul_res_ready, bus.div_res_ready}, 64'd3);
    chk("abort stall", 64'(stall_out), 64'd1);
    n = 0;
    while (bus.mul_res_ready && n < 30) begin
      cyc();
      #1;
      n++;
    end
    chk("abort drained", 64'(n < 30), 64'd1);
    chk("abort hilo kept", {hi, lo}, {eh, el});
    chk("abort no early issue", 64'(mul_issues - m0), 64'd1);
    finish_op("abort reissue");
    chk("abort total pulses", 64'(mul_issues - m0), 64'd2);
    chk("abort new result", {hi, lo}, 64'hFFFFFFFF_FFFFFFFA);
    eh = 32'hFFFFFFFF;
    el = 32'hFFFFFFFA;

    // Flush coinciding with the result in MUL_WAIT: discard, straight to IDLE
    mul_lat = 2;
    cyc();
    drv(1'b1, MULT, 32'd3, 32'd4);
    #1;
    n = 0;
    while (!bus.mul_res_valid && n < 30) begin
      cyc();
      #1;
      n++;
    end
    chk("coincide res seen", 64'(bus.mul_res_valid), 64'd1);
    flush    = 1'b1;
    ex_valid = 1'b0;
    cyc();
    flush = 1'b0;
    #1;
    chk("coincide ready low", 64'(bus.mul_res_ready), 64'd0);
    chk("coincide hilo kept", {hi, lo}, {eh, el});
    drv(1'b1, MULT, 32'd2, 32'd3);
    #1;
    chk("coincide in idle", 64'(stall_out), 64'd1);
    finish_op("coincide next");
    chk("coincide next result", {hi, lo}, 64'h00000000_00000006);
    eh = 32'd0;
    el = 32'd6;

    // Flush has priority over MTHI and over issue in IDLE
    m0 = mul_issues;
    cyc();
    flush = 1'b1;
    drv(1'b1, MTHI, 32'hDEADBEEF, 32'd0);
    cyc();
    drv(1'b1, MULT, 32'd1, 32'd1);
    cyc();
    flush = 1'b0;
    drv(1'b0, NOP, 32'd0, 32'd0);
    #1;
    chk("flushprio hi", 64'(hi), 64'(eh));
    chk("flushprio no issue", 64'(mul_issues - m0), 64'd0);
    chk("flushprio ready", 64'(bus.mul_res_ready), 64'd0);

    // DIVU held in DONE by pipe_stall for three cycles: exactly one issue
    div_lat = 3;
    d0 = div_issues;
    cyc();
    pipe_stall = 1'b1;
    drv(1'b1, DIVU, 32'd100, 32'd7);
    #1;
    chk("hold stall_issue", 64'(stall_out), 64'd1);
    n = 0;
    while (stall_out && n < 30) begin
      cyc();
      #1;
      n++;
    end
    chk("hold reached done", 64'(n < 30), 64'd1);
    for (int k = 0; k < 2; k++) begin
      cyc();
      #1;
      chk($sformatf("hold done%0d", k + 2), {stall_out, bus.div_opn_valid}, 64'd0);
    end
    cyc();
    pipe_stall = 1'b0;
    #1;
    chk("hold release", 64'(stall_out), 64'd0);
    cyc();
    drv(1'b0, NOP, 32'd0, 32'd0);
    cyc();
    cyc();
    #1;
    chk("hold div_pulses", 64'(div_issues - d0), 64'd1);
    chk("hold hilo", {hi, lo}, 64'h00000002_0000000E);

    // Reset mid-divide overrides flush and abandons the operation
    div_lat = 5;
    cyc();
    drv(1'b1, DIV, 32'd9, 32'd2);
    #1;
    cyc();
    #1;
    chk("midrst ready", 64'(bus.div_res_ready), 64'd1);
    cyc();
    rst   = 1'b1;
    flush = 1'b1;
    drv(1'b0, NOP, 32'd0, 32'd0);
    cyc();
    rst   = 1'b0;
    flush = 1'b0;
    #1;
    chk("midrst hilo", {hi, lo}, 64'd0);
    chk("midrst ctrl", {stall_out, bus.div_res_ready, bus.mul_res_ready, bus.div_opn_valid}, 64'd0);
    chk("midrst operands", {bus.div_a, bus.mul_a}, 64'd0);
    mul_lat = 2;
    cyc();
    drv(1'b1, MULTU, 32'd7, 32'd6);
    #1;
    chk("midrst recover stall", 64'(stall_out), 64'd1);
    finish_op("midrst recover");
    chk("midrst recover hilo", {hi, lo}, 64'h00000000_0000002A);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/muldiv_ctrl.md
MULDIV_CTRL -- requirements
Module: muldiv_ctrl

Interface
REQ-001 SHALL have port clk  in  1  clock; all state updates on its rising edge.
REQ-002 SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have port ex_valid  in  1  EX-stage instruction valid.
REQ-004 SHALL have port ex_op  in  3  operation code; encodings fixed in REQ-031.
REQ-005 SHALL have port rs_val  in  32  operand A / MTHI-MTLO source.
REQ-006 SHALL have port rt_val  in  32  operand B.
REQ-007 SHALL have port pipe_stall  in  1  stall from another pipeline source.
REQ-008 SHALL have port flush  in  1  exception/flush; cancels the EX operation.
REQ-009 SHALL have port stall_out  out  1  holds EX until the mul/div result is committed.
REQ-010 SHALL have ports mul_opn_valid out 1, mul_a out 32, mul_b out 32, mul_sign out 1, mul_res_ready out 1, mul_res_valid in 1, mul_result in 64  multiplier handshake.
REQ-011 SHALL have ports div_opn_valid out 1, div_a out 32, div_b out 32, div_sign out 1, div_res_ready out 1, div_res_valid in 1, div_result in 64 ({rem,quot})  divider handshake.
REQ-012 SHALL have ports hi out 32, lo out 32  architectural HI/LO registers.

Function
REQ-013 SHALL implement FSM states IDLE, MUL_WAIT, DIV_WAIT, DONE, ABORT.
REQ-014 In IDLE, ex_valid && !flush && op in {MULT,MULTU} SHALL pulse mul_opn_valid for exactly one cycle, drive mul_a=rs_val, mul_b=rt_val, mul_sign=(op==MULT), and move to MUL_WAIT.
REQ-015 In IDLE, ex_valid && !flush && op in {DIV,DIVU} with rt_val!=0 SHALL pulse div_opn_valid one cycle with div_sign=(op==DIV) and move to DIV_WAIT.
REQ-016 DIV/DIVU with rt_val==0 SHALL not start the divider, leave HI/LO unchanged, and not stall.
REQ-017 MTHI/MTLO with ex_valid && !flush in IDLE SHALL write rs_val into hi/lo at the clock edge, zero latency, no stall.
REQ-018 stall_out SHALL be combinationally 1 whenever ex_valid and op in {MULT,MULTU,DIV,DIVU} (divisor nonzero for DIV/DIVU) and state != DONE, including the issue cycle and all ABORT cycles.
REQ-019 mul_res_ready SHALL be 1 in MUL_WAIT and ABORT; div_res_ready 1 in DIV_WAIT and ABORT; 0 otherwise.
REQ-020 In MUL_WAIT/DIV_WAIT on res_valid: hi<=result[63:32], lo<=result[31:0], next state DONE.
REQ-021 DONE SHALL deassert stall_out; stay in DONE while pipe_stall=1 (no re-issue of the same instruction), else return to IDLE.
REQ-022 flush in MUL_WAIT/DIV_WAIT SHALL go to ABORT; HI/LO never written by the cancelled operation.
REQ-023 ABORT SHALL drain the in-flight unit's res_valid, discard the result, then go to IDLE; if res_valid and flush coincide in WAIT, result is discarded and next state is IDLE.
REQ-024 flush in DONE or IDLE SHALL go to IDLE with no HI/LO write; flush has priority over every issue and MTHI/MTLO write.
REQ-025 At most one unit SHALL be in flight at any time; a new op is not issued before IDLE.

Reset
REQ-026 rst SHALL force state=IDLE, hi=0, lo=0, all opn_valid/res_ready=0, stall_out=0 next cycle.
REQ-027 rst mid-operation SHALL abandon the operation without draining; the units are reset by the same rst.
REQ-028 mul_a/mul_b/div_a/div_b SHALL reset to 0.
REQ-029 rst SHALL override flush and all other inputs.
REQ-030 No output SHALL be X after the first reset edge.

Structure
REQ-031 Shared package SHALL hold op encodings NOP=0, MULT=1, MULTU=2, DIV=3, DIVU=4, MTHI=5, MTLO=6, and the FSM state enum.
REQ-032 Arithmetic SHALL live only in the multiplier/divider; this block is control plus the HI/LO register file.
REQ-033 One natural sub-module: hilo_reg (HI/LO storage with write-enable and source select).

Verification
REQ-034 MULT rs=0xFFFFFFFE, rt=3 -> one mul_opn_valid pulse, stall until DONE, hi=0xFFFFFFFF, lo=0xFFFFFFFA.
REQ-035 MULTU rs=0xFFFFFFFF, rt=2 -> hi=0x00000001, lo=0xFFFFFFFE, mul_sign=0.
REQ-036 DIV rs=7, rt=0 -> no div_opn_valid, no stall, hi/lo unchanged.
REQ-037 MULT issued, flush on second WAIT cycle -> ABORT, result drained, hi/lo unchanged, next MULT issues normally.
REQ-038 MTHI 0x12345678 then MTLO 0x9ABCDEF0 back-to-back -> hi=0x12345678, lo=0x9ABCDEF0, stall_out never 1.
REQ-039 DIVU 100/7 with pipe_stall=1 for 3 cycles in DONE -> exactly one div_opn_valid, hi=2, lo=14.
